// File: rtl/mux2x24_arb.sv
// Two-channel round-robin arbiter feeding one registered W-bit output stream with a channel tag.
// Define MUX_FIXED_PRI_EN to give channel 0 fixed priority under contention (default: round-robin).
module mux2x24_arb #(
  parameter int W    = 24,
  parameter int CNTW = 16
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [W-1:0]    D0,
  input  logic            V0,
  output logic            R0,
  input  logic [W-1:0]    D1,
  input  logic            V1,
  output logic            R1,
  output logic [W-1:0]    Q,
  output logic            QV,
  input  logic            QR,
  output logic            S,
  output logic [CNTW-1:0] CNT0,
  output logic [CNTW-1:0] CNT1
);

  logic         en;
  logic         f0, f1;
  logic         last;
  logic [W-1:0] hd0, hd1;
  logic         g0, g1;
  logic         ld;
  logic         acc0, acc1;

`ifdef MUX_FIXED_PRI_EN
  assign g1 = f1 & ~f0;
`else
  // Under contention the channel not served last wins; LAST resets to 1 so channel 0 goes first.
  assign g1 = f1 & (~f0 | ~last);
`endif
  assign g0 = f0 & ~g1;

  assign ld = (~QV | QR) & (f0 | f1);

  // A full hold register still takes a new word on the edge it is unloaded.
  assign R0   = en & (~f0 | (g0 & ld));
  assign R1   = en & (~f1 | (g1 & ld));
  assign acc0 = V0 & R0;
  assign acc1 = V1 & R1;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      en   <= 1'b0;
      f0   <= 1'b0;
      f1   <= 1'b0;
      last <= 1'b1;
      Q    <= '0;
      QV   <= 1'b0;
      S    <= 1'b0;
      CNT0 <= '0;
      CNT1 <= '0;
    end else begin
      en <= 1'b1;

      if (acc0) begin
        f0   <= 1'b1;
        CNT0 <= CNT0 + CNTW'(1);
      end else if (ld && g0) begin
        f0 <= 1'b0;
      end

      if (acc1) begin
        f1   <= 1'b1;
        CNT1 <= CNT1 + CNTW'(1);
      end else if (ld && g1) begin
        f1 <= 1'b0;
      end

      if (ld) begin
        Q    <= g1 ? hd1 : hd0;
        S    <= g1;
        QV   <= 1'b1;
        last <= g1;
      end else if (QV && QR) begin
        QV <= 1'b0;
      end
    end
  end

  // NOTE: hold data needs no reset; it is only ever read while its flag is set.
  always_ff @(posedge CLK) begin
    if (acc0) hd0 <= D0;
    if (acc1) hd1 <= D1;
  end

endmodule

// File: tb/tb_mux2x24_arb.sv
// Self-checking bench for mux2x24_arb: directed steps, per-channel scoreboard queues checked as words leave Q.
// Counters are built 4 bits wide so wrap-around is reachable quickly.
module tb_mux2x24_arb;

  localparam int W    = 24;
  localparam int CNTW = 4;

  logic            CLK = 1'b0;
  logic            RST;
  logic [W-1:0]    D0, D1;
  logic            V0, V1, R0, R1;
  logic [W-1:0]    Q;
  logic            QV, QR, S;
  logic [CNTW-1:0] CNT0, CNT1;

  int tests = 0;
  int fails = 0;

  logic [W-1:0] q0[$];
  logic [W-1:0] q1[$];

  mux2x24_arb #(.W(W), .CNTW(CNTW)) dut (
    .CLK(CLK), .RST(RST),
    .D0(D0), .V0(V0), .R0(R0),
    .D1(D1), .V1(V1), .R1(R1),
    .Q(Q), .QV(QV), .QR(QR), .S(S),
    .CNT0(CNT0), .CNT1(CNT1)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b0;
    V0  = 1'b0;
    V1  = 1'b0;
    repeat (2) step();
    q0.delete();
    q1.delete();
    RST = 1'b1;
    step();
    step();
  endtask

  // Scoreboard: handshakes seen mid-cycle complete on the next rising edge.
  always @(negedge CLK) begin
    if (RST) begin
      if (QV && QR) begin
        if (S == 1'b0) begin
          check("sb_q0_nonempty", 32'(q0.size() > 0), 32'd1);
          if (q0.size() > 0) check("sb_q0_data", 32'(Q), 32'(q0.pop_front()));
        end else begin
          check("sb_q1_nonempty", 32'(q1.size() > 0), 32'd1);
          if (q1.size() > 0) check("sb_q1_data", 32'(Q), 32'(q1.pop_front()));
        end
      end
      if (V0 && R0) q0.push_back(D0);
      if (V1 && R1) q1.push_back(D1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    logic          a0, a1;
    int            n;
    logic [W-1:0]  exp_q;
    logic          exp_s;

    // Reset and ready release.
    RST = 1'b0; QR = 1'b1; V0 = 1'b1; V1 = 1'b1;
    D0 = 24'h0F0F0F; D1 = 24'hF0F0F0;
    repeat (3) step();
    check("rst_r0", 32'(R0), 32'd0);
    check("rst_r1", 32'(R1), 32'd0);
    check("rst_q", 32'(Q), 32'd0);
    check("rst_qv", 32'(QV), 32'd0);
    check("rst_cnt0", 32'(CNT0), 32'd0);
    check("rst_cnt1", 32'(CNT1), 32'd0);
    RST = 1'b1;
    #1;
    check("rel_r0_first", 32'(R0), 32'd0);
    check("rel_r1_first", 32'(R1), 32'd0);
    step();
    check("rel_cnt0_noacc", 32'(CNT0), 32'd0);
    check("rel_cnt1_noacc", 32'(CNT1), 32'd0);
    check("rel_r0_second", 32'(R0), 32'd1);
    check("rel_r1_second", 32'(R1), 32'd1);
    V0 = 1'b0; V1 = 1'b0;

    // Single-channel latency.
    D0 = 24'h123456; V0 = 1'b1;
    step();
    V0 = 1'b0;
    step();
    check("lat_q", 32'(Q), 32'h123456);
    check("lat_s", 32'(S), 32'd0);
    check("lat_qv", 32'(QV), 32'd1);
    check("lat_cnt0", 32'(CNT0), 32'd1);
    step();
    check("lat_qv_drop", 32'(QV), 32'd0);

    // Continuous contention.
    do_reset();
    QR = 1'b1; V0 = 1'b1; V1 = 1'b1;
    D0 = 24'h000001; D1 = 24'h100001;
    for (int c = 1; c <= 10; c++) begin
      #2;
      a0 = R0; a1 = R1;
      @(posedge CLK); #1;
      if (a0) D0 = D0 + 24'd1;
      if (a1) D1 = D1 + 24'd1;
      if (c >= 2) begin
`ifdef MUX_FIXED_PRI_EN
        exp_s = 1'b0;
        exp_q = 24'(1 + (c - 2));
`else
        exp_s = 1'((c - 2) % 2);
        exp_q = exp_s ? 24'(24'h100001 + (c - 2) / 2) : 24'(1 + (c - 2) / 2);
`endif
        check($sformatf("rr_s_%0d", c), 32'(S), 32'(exp_s));
        check($sformatf("rr_q_%0d", c), 32'(Q), 32'(exp_q));
      end
    end
`ifdef MUX_FIXED_PRI_EN
    check("rr_cnt0", 32'(CNT0), 32'd10);
    check("rr_cnt1", 32'(CNT1), 32'd1);
`else
    check("rr_cnt0", 32'(CNT0), 32'd6);
    check("rr_cnt1", 32'(CNT1), 32'd5);
`endif
    V0 = 1'b0; V1 = 1'b0;
    repeat (4) step();

    // Backpressure.
    QR = 1'b0; D0 = 24'hAAAAAA; V0 = 1'b1;
    step();
    V0 = 1'b0;
    step();
    check("bp_load_q", 32'(Q), 32'hAAAAAA);
    check("bp_load_qv", 32'(QV), 32'd1);
    D0 = 24'hB00001; D1 = 24'hC00001; V0 = 1'b1; V1 = 1'b1;
    step();
    for (int c = 0; c < 5; c++) begin
      check("bp_q", 32'(Q), 32'hAAAAAA);
      check("bp_s", 32'(S), 32'd0);
      check("bp_qv", 32'(QV), 32'd1);
      check("bp_r0", 32'(R0), 32'd0);
      check("bp_r1", 32'(R1), 32'd0);
      step();
    end
    V0 = 1'b0; V1 = 1'b0; QR = 1'b1;
    step();
`ifdef MUX_FIXED_PRI_EN
    check("bp_drain1_q", 32'(Q), 32'hB00001);
    check("bp_drain1_s", 32'(S), 32'd0);
    step();
    check("bp_drain2_q", 32'(Q), 32'hC00001);
    check("bp_drain2_s", 32'(S), 32'd1);
`else
    check("bp_drain1_q", 32'(Q), 32'hC00001);
    check("bp_drain1_s", 32'(S), 32'd1);
    step();
    check("bp_drain2_q", 32'(Q), 32'hB00001);
    check("bp_drain2_s", 32'(S), 32'd0);
`endif
    step();
    check("bp_drain_qv", 32'(QV), 32'd0);

    // Counter wrap on channel 1.
    do_reset();
    QR = 1'b1; V1 = 1'b1; D1 = 24'h500000; n = 0;
    for (int c = 0; c < 100 && n < 17; c++) begin
      #2;
      a1 = R1;
      @(posedge CLK); #1;
      if (a1) begin
        n++;
        D1 = D1 + 24'd1;
      end
      if (n == 17) V1 = 1'b0;
    end
    V1 = 1'b0;
    check("wrap_accepts", 32'(n), 32'd17);
    check("wrap_cnt1", 32'(CNT1), 32'd1);
    check("wrap_cnt0", 32'(CNT0), 32'd0);
    repeat (3) step();
    check("wrap_drain_qv", 32'(QV), 32'd0);

    // Asynchronous reset mid-stream.
    do_reset();
    QR = 1'b0; V0 = 1'b1; V1 = 1'b1;
    D0 = 24'hD00001; D1 = 24'hE00001;
    step();
    step();
    V0 = 1'b0; V1 = 1'b0;
    check("ar_pre_qv", 32'(QV), 32'd1);
    check("ar_pre_cnt0", 32'(CNT0), 32'd2);
    #3;
    RST = 1'b0;
    #1;
    q0.delete();
    q1.delete();
    check("ar_qv", 32'(QV), 32'd0);
    check("ar_q", 32'(Q), 32'd0);
    check("ar_s", 32'(S), 32'd0);
    check("ar_cnt0", 32'(CNT0), 32'd0);
    check("ar_cnt1", 32'(CNT1), 32'd0);
    step();
    RST = 1'b1; QR = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      check("ar_no_stale_qv", 32'(QV), 32'd0);
    end

    check("sb_q0_empty_end", 32'(q0.size()), 32'd0);
    check("sb_q1_empty_end", 32'(q1.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
